decoder_scan_seq: RTL and testbench

//   Parametrised SEL_W-to-2**SEL_W one-hot decoder with enable and registered outputs.

---
 rtl/decoder_scan_seq_pkg.sv | 28 ++
 rtl/decoder_scan_seq_onehot_decode.sv | 17 +
 rtl/decoder_scan_seq.sv | 119 +++++++++++
 tb/tb_decoder_scan_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_seq_pkg.sv
// Shared types and constants for the one-hot decoder / auto-scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Output polarity selected by macro ACTIVE_LOW_OUT_EN.
package decoder_scan_pkg;

  // Controller states: outputs parked, direct decode, or auto-walk
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Number of one-hot lines produced by a select of width sel_w
  function automatic int num_out(input int sel_w);
    return 2 ** sel_w;
  endfunction

`ifdef ACTIVE_LOW_OUT_EN
  // Active-low select lines: the chosen line is pulled to 0
  localparam logic OUT_ACTIVE   = 1'b0;
  localparam logic OUT_INACTIVE = 1'b1;
`else
  // Active-high select lines: the chosen line is driven to 1
  localparam logic OUT_ACTIVE   = 1'b1;
  localparam logic OUT_INACTIVE = 1'b0;
`endif

endpackage

// File: rtl/decoder_scan_seq_onehot_decode.sv
// Combinational index -> one-hot vector (bit idx set, all others clear).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; always produces a valid vector.
module onehot_decode #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(2**SEL_W)-1:0] oh
);

  // Set exactly the addressed bit
  always_comb begin
    oh      = '0;
    oh[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_seq.sv
// One-hot decoder with enable, plus auto-scan mode walking all lines with programmable dwell.
// Latency: 1 cycle from sampled inputs to registered D/cur_sel/wrap; no comb input->output path.
// Backpressure: none; free-running. D polarity set by macro ACTIVE_LOW_OUT_EN.
module decoder_scan_seq
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [DWELL_W-1:0]          dwell,
  input  logic                        load,
  output logic [num_out(SEL_W)-1:0]   D,
  output logic [SEL_W-1:0]            cur_sel,
  output logic                        wrap
);

  localparam int NUM_OUT = num_out(SEL_W);

  state_t               state_q;
  state_t               state_d;
  logic [DWELL_W-1:0]   cnt_q;
  logic [DWELL_W-1:0]   cnt_d;
  logic [SEL_W-1:0]     cur_sel_d;
  logic                 wrap_d;
  logic [NUM_OUT-1:0]   oh_next;
  logic [NUM_OUT-1:0]   d_d;

  // Decode the index that will be current next cycle, so D and cur_sel always agree
  onehot_decode #(
    .SEL_W (SEL_W)
  ) u_onehot_decode (
    .idx (cur_sel_d),
    .oh  (oh_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state depends only on enable/mode; every state can reach every other in one cycle
  always_comb begin
    state_d = ST_IDLE;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (mode) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_DIRECT;
    end
  end

  // Next index, dwell count and wrap flag for the state being entered
  always_comb begin
    cur_sel_d = cur_sel;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    unique case (state_d)
      ST_IDLE: begin
        // index and count park so a later DIRECT/SCAN can resume from known values
      end
      ST_DIRECT: begin
        cur_sel_d = sel;
        cnt_d     = '0;   // any partial dwell from a previous scan is dropped
      end
      ST_SCAN: begin
        if ((state_q != ST_SCAN) || load) begin
          // entry or explicit restart: start at sel, no wrap even if sel is 0
          cur_sel_d = sel;
          cnt_d     = '0;
        end else if (cnt_q >= dwell) begin
          // >= so a dwell lowered below the running count advances immediately
          cnt_d     = '0;
          cur_sel_d = cur_sel + 1'b1;
          wrap_d    = &cur_sel;
        end else begin
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Polarity-adjusted output vector; nothing asserted while idle
  always_comb begin
    d_d = {NUM_OUT{OUT_INACTIVE}};
    if (state_d != ST_IDLE) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        d_d[i] = oh_next[i] ? OUT_ACTIVE : OUT_INACTIVE;
      end
    end
  end

  // Registered datapath: outputs, index, dwell count
  always_ff @(posedge clk) begin
    if (rst) begin
      D       <= {NUM_OUT{OUT_INACTIVE}};
      cur_sel <= '0;
      wrap    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      D       <= d_d;
      cur_sel <= cur_sel_d;
      wrap    <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed self-checking bench for decoder_scan_seq (SEL_W=2, DWELL_W=8).
// Expected D levels follow ACTIVE_LOW_OUT_EN when the build defines it.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_decoder_scan_seq;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [1:0] sel;
  logic [7:0] dwell;
  logic       load;
  logic [3:0] D;
  logic [1:0] cur_sel;
  logic       wrap;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  decoder_scan_seq #(
    .SEL_W   (2),
    .DWELL_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .mode    (mode),
    .sel     (sel),
    .dwell   (dwell),
    .load    (load),
    .D       (D),
    .cur_sel (cur_sel),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected D for an active-high one-hot pattern, converted to the build's polarity
  function automatic logic [3:0] lvl(input logic [3:0] hi);
`ifdef ACTIVE_LOW_OUT_EN
    return ~hi;
`else
    return hi;
`endif
  endfunction

  function automatic logic [3:0] oh(input int idx);
    logic [3:0] v;
    v = 4'b0001;
    return v << idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] exp_d, input int exp_sel, input logic exp_wrap);
    chk({tag, ".D"}, 32'(D), 32'(exp_d));
    chk({tag, ".cur_sel"}, 32'(cur_sel), 32'(exp_sel));
    chk({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  // Every cycle: D is either fully inactive or the single line named by cur_sel
  always @(negedge clk) begin
    if (started) begin
      checks++;
      assert ((D === lvl(4'b0000)) || (D === lvl(oh(int'(cur_sel)))))
      else begin
        errors++;
        $error("FAIL onehot observed=%0h expected=%0h_or_%0h", D, lvl(4'b0000), lvl(oh(int'(cur_sel))));
      end
    end
  end

  int seq3 [9] = '{2, 2, 3, 3, 0, 0, 1, 1, 2};

  initial begin
    // 1. reset with arbitrary inputs
    rst = 1'b1; enable = 1'b1; mode = 1'b1; sel = 2'd3; dwell = 8'd0; load = 1'b1;
    step();
    started = 1;
    step();
    chk_all("reset", lvl(4'b0000), 0, 1'b0);
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    step();
    chk_all("idle_after_reset", lvl(4'b0000), 0, 1'b0);

    // 2. direct decode of each index
    enable = 1'b1; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
      chk_all($sformatf("direct%0d", s), lvl(oh(s)), s, 1'b0);
    end
    enable = 1'b0;
    step();
    chk_all("direct_disable", lvl(4'b0000), 3, 1'b0);

    // 3. scan from 2 with dwell=1; sel changes after entry must be ignored
    enable = 1'b1; mode = 1'b1; sel = 2'd2; dwell = 8'd1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_all($sformatf("scan_d1_%0d", i), lvl(oh(seq3[i])), seq3[i], (i == 4));
      if (i == 0) sel = 2'd0;
    end

    // 4. dwell=0 scan from 3, then load overriding a wrap step
    enable = 1'b0;
    step();
    chk_all("scan_park", lvl(4'b0000), 2, 1'b0);
    enable = 1'b1; sel = 2'd3; dwell = 8'd0;
    step();
    chk_all("scan_d0_entry", lvl(oh(3)), 3, 1'b0);
    step(); chk_all("scan_d0_a", lvl(oh(0)), 0, 1'b1);
    step(); chk_all("scan_d0_b", lvl(oh(1)), 1, 1'b0);
    step(); chk_all("scan_d0_c", lvl(oh(2)), 2, 1'b0);
    step(); chk_all("scan_d0_d", lvl(oh(3)), 3, 1'b0);
    load = 1'b1; sel = 2'd1;
    step(); chk_all("load_over_wrap", lvl(oh(1)), 1, 1'b0);
    load = 1'b0;
    step(); chk_all("after_load", lvl(oh(2)), 2, 1'b0);
    load = 1'b1; sel = 2'd0;
    step(); chk_all("load_at_zero", lvl(oh(0)), 0, 1'b0);
    load = 1'b0;

    // 5. mid-scan events
    dwell = 8'd5;
    step(); chk_all("hold_a", lvl(oh(0)), 0, 1'b0);
    step(); chk_all("hold_b", lvl(oh(0)), 0, 1'b0);
    dwell = 8'd1;
    step(); chk_all("dwell_lowered", lvl(oh(1)), 1, 1'b0);
    dwell = 8'd5;
    step(); chk_all("hold_c", lvl(oh(1)), 1, 1'b0);
    mode = 1'b0; sel = 2'd0;
    step(); chk_all("leave_scan", lvl(oh(0)), 0, 1'b0);
    mode = 1'b1; sel = 2'd3;
    step(); chk_all("enter_from_direct", lvl(oh(3)), 3, 1'b0);
    step(); chk_all("hold_d", lvl(oh(3)), 3, 1'b0);
    enable = 1'b0;
    step(); chk_all("disable_mid_scan", lvl(4'b0000), 3, 1'b0);
    enable = 1'b1; sel = 2'd2;
    step(); chk_all("reenable", lvl(oh(2)), 2, 1'b0);
    step(); chk_all("hold_e", lvl(oh(2)), 2, 1'b0);
    rst = 1'b1;
    step(); chk_all("reset_mid_hold", lvl(4'b0000), 0, 1'b0);
    rst = 1'b0; sel = 2'd1;
    step(); chk_all("scan_after_reset", lvl(oh(1)), 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
